des_seq_ctrl: RTL

APB-programmed sequencer for the 16-round DES datapath. Software writes a start command with an encrypt/decrypt direction. The block then drives the datapath through a load cycle, sixteen round cycles and a final output cycle, issuing round index, key-rotation amount and direction on each cycle. Completion is reported through a sticky status bit and a level interrupt. It sits beside the 64-bit data/key register slave on the same APB segment.

---
 rtl/des_seq_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/des_seq_ctrl.sv
// APB-programmed sequencer for the 16-round DES datapath.
// It issues load, round and final controls and reports completion via sticky DONE and irq.
module des_seq_ctrl (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        dp_load,
    output logic        dp_round_en,
    output logic [3:0]  dp_round,
    output logic [1:0]  dp_shift,
    output logic        dp_decrypt,
    output logic        dp_final,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [3:0]  round_r, round_next_s;
    logic        decrypt_r, decrypt_next_s;
    logic        done_r, done_next_s;
    logic        irq_en_r, irq_en_next_s;
    logic        dp_load_r, dp_round_en_r, dp_final_r, irq_r;
    logic [1:0]  dp_shift_r;

    logic        access_s, wr_s, rd_s, addr_ok_s, busy_s;
    logic        ctrl_wr_s, abort_s, start_s, start_err_s;
    logic [3:0]  addr_s;
    logic        unused_s;

    // Decrypt keeps the first round unrotated so the schedule mirrors encryption.
    function automatic logic [1:0] shift_amount(input logic [3:0] rnd, input logic decrypt);
        logic [1:0] amt;
        case (rnd)
            4'd0:              amt = decrypt ? 2'd0 : 2'd1;
            4'd1, 4'd8, 4'd15: amt = 2'd1;
            default:           amt = 2'd2;
        endcase
        return amt;
    endfunction

    assign addr_s      = PADDR[3:0];
    assign access_s    = PSEL & PENABLE;
    assign wr_s        = access_s & PWRITE;
    assign rd_s        = access_s & ~PWRITE;
    assign addr_ok_s   = (addr_s == 4'h0) | (addr_s == 4'h4) | (addr_s == 4'h8);
    assign busy_s      = (state_r != ST_IDLE);
    assign ctrl_wr_s   = wr_s & (addr_s == 4'h0);
    assign abort_s     = ctrl_wr_s & PWDATA[2];
    assign start_s     = ctrl_wr_s & PWDATA[0] & ~PWDATA[2] & ~busy_s;
    assign start_err_s = ctrl_wr_s & PWDATA[0] & ~PWDATA[2] & busy_s;
    assign unused_s    = ^{PADDR[11:4], PWDATA[31:3]};

    // Zero-wait APB response and read mux
    always_comb begin
        PREADY  = access_s;
        PSLVERR = access_s & (~addr_ok_s | start_err_s);
        PRDATA  = 32'd0;
        if (rd_s) begin
            case (addr_s)
                4'h4:    PRDATA = {24'd0, round_r, 2'd0, done_r, busy_s};
                4'h8:    PRDATA = {31'd0, irq_en_r};
                default: PRDATA = 32'd0;
            endcase
        end else begin
            PRDATA = 32'd0;
        end
    end

    // Sequencer next state plus register-file updates
    always_comb begin
        state_next_s   = state_r;
        round_next_s   = round_r;
        decrypt_next_s = decrypt_r;
        done_next_s    = done_r;
        irq_en_next_s  = irq_en_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s   = ST_LOAD;
                    decrypt_next_s = PWDATA[1];
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = abort_s ? ST_IDLE : ST_ROUND;
                round_next_s = 4'd0;
            end
            ST_ROUND: begin
                if (abort_s) begin
                    state_next_s = ST_IDLE;
                    round_next_s = 4'd0;
                end else if (round_r == 4'd15) begin
                    state_next_s = ST_FINAL;
                    round_next_s = 4'd0;
                end else begin
                    round_next_s = round_r + 4'd1;
                end
            end
            ST_FINAL: begin
                state_next_s = ST_IDLE;
                round_next_s = 4'd0;
            end
            default: begin
                state_next_s = ST_IDLE;
                round_next_s = 4'd0;
            end
        endcase

        // Completion outranks a same-cycle software clear
        if ((state_r == ST_FINAL) && !abort_s) begin
            done_next_s = 1'b1;
        end else if (start_s) begin
            done_next_s = 1'b0;
        end else if (wr_s && (addr_s == 4'h4) && PWDATA[1]) begin
            done_next_s = 1'b0;
        end else begin
            done_next_s = done_r;
        end

        if (wr_s && (addr_s == 4'h8)) begin
            irq_en_next_s = PWDATA[0];
        end else begin
            irq_en_next_s = irq_en_r;
        end
    end

    // State, register file and registered datapath controls
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_r       <= ST_IDLE;
            round_r       <= 4'd0;
            decrypt_r     <= 1'b0;
            done_r        <= 1'b0;
            irq_en_r      <= 1'b0;
            dp_load_r     <= 1'b0;
            dp_round_en_r <= 1'b0;
            dp_shift_r    <= 2'd0;
            dp_final_r    <= 1'b0;
            irq_r         <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            round_r       <= round_next_s;
            decrypt_r     <= decrypt_next_s;
            done_r        <= done_next_s;
            irq_en_r      <= irq_en_next_s;
            dp_load_r     <= (state_next_s == ST_LOAD);
            dp_round_en_r <= (state_next_s == ST_ROUND);
            dp_shift_r    <= (state_next_s == ST_ROUND) ?
                             shift_amount(round_next_s, decrypt_next_s) : 2'd0;
            dp_final_r    <= (state_next_s == ST_FINAL);
            irq_r         <= done_next_s & irq_en_next_s;
        end
    end

    assign dp_load     = dp_load_r;
    assign dp_round_en = dp_round_en_r;
    assign dp_round    = round_r;
    assign dp_shift    = dp_shift_r;
    assign dp_decrypt  = decrypt_r;
    assign dp_final    = dp_final_r;
    assign irq         = irq_r;

endmodule
